// File: rtl/mac_mgnt_req.sv
// mac_mgnt_req: system-side initiator for the per-port MAC management request bus.
// Optional ack/read-byte timeout is built in when MGNT_REQ_TIMEOUT_EN is defined.
module mac_mgnt_req #(
  parameter int MAX_BYTES   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rstn_sys,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [7:0]             cmd_addr,
  input  logic [3:0]             cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   sys_req_valid,
  output logic                   sys_req_wr,
  output logic [7:0]             sys_req_addr,
  input  logic                   sys_req_ack,
  output logic [7:0]             sys_req_data,
  output logic                   sys_req_data_valid,
  input  logic [7:0]             sys_resp_data,
  input  logic                   sys_resp_data_valid
);

  // state | meaning
  // IDLE  | ready for a command
  // REQ   | request strobe held, waiting for ack
  // WDATA | streaming write bytes, one per cycle
  // RDATA | collecting read bytes as they arrive
  // DONE  | one-cycle response pulse

  localparam int DW = 8*MAX_BYTES;

  typedef enum logic [2:0] {IDLE, REQ, WDATA, RDATA, DONE} state_t;

  state_t          state_q, state_d;
  logic            wr_q;
  logic [7:0]      addr_q;
  logic [3:0]      len_q, cnt_q, len_eff;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic            accept, last_byte, rd_take, tmo_abort;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == 4'd0) len_eff = 4'd1;
    else if (int'(cmd_len) > MAX_BYTES) len_eff = 4'(MAX_BYTES);
  end

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign last_byte = (cnt_q == len_q - 4'd1);
  assign rd_take   = (state_q == RDATA) && sys_resp_data_valid;

`ifdef MGNT_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // An ack or byte arriving on the terminal cycle still wins over the timeout.
  assign tmo_abort = (tmo_q == '0) &&
                     (((state_q == REQ) && !sys_req_ack) ||
                      ((state_q == RDATA) && !sys_resp_data_valid));

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept || rd_take) tmo_q <= TW'(TIMEOUT_CYC - 1);
      else if (((state_q == REQ) || (state_q == RDATA)) && (tmo_q != '0)) tmo_q <= tmo_q - TW'(1);
      if (accept) err_q <= 1'b0;
      else if (tmo_abort) err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
  assign tmo_abort  = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    cmd_ready          = 1'b0;
    sys_req_valid      = 1'b0;
    sys_req_data_valid = 1'b0;
    rsp_valid          = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = REQ;
      end
      REQ: begin
        sys_req_valid = 1'b1;
        if (sys_req_ack) state_d = wr_q ? WDATA : RDATA;
        else if (tmo_abort) state_d = DONE;
      end
      WDATA: begin
        sys_req_data_valid = 1'b1;
        if (last_byte) state_d = DONE;
      end
      RDATA: begin
        if ((rd_take && last_byte) || tmo_abort) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write bytes leave from the bottom of a shift register.
  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      wr_q    <= cmd_wr;
      addr_q  <= cmd_addr;
      len_q   <= len_eff;
      cnt_q   <= 4'd0;
      wdata_q <= cmd_wdata;
      rdata_q <= '0;
    end else if (state_q == WDATA) begin
      wdata_q <= wdata_q >> 8;
      cnt_q   <= cnt_q + 4'd1;
    end else if (rd_take) begin
      rdata_q[{cnt_q, 3'b000} +: 8] <= sys_resp_data;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign sys_req_wr   = wr_q;
  assign sys_req_addr = addr_q;
  assign sys_req_data = sys_req_data_valid ? wdata_q[7:0] : 8'h00;
  assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_mac_mgnt_req.sv
// tb_mac_mgnt_req: table vectors, random transactions against a byte-level model,
// and hand sequences for reset abort, held cmd_valid and (if built in) timeouts.
module tb_mac_mgnt_req;
  localparam int MAXB = 8;
`ifdef MGNT_REQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rstn_sys;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err;
  logic        sys_req_valid, sys_req_wr, sys_req_ack;
  logic [7:0]  sys_req_addr, sys_req_data, sys_resp_data;
  logic        sys_req_data_valid, sys_resp_data_valid;

  always #5 clk = ~clk;

  mac_mgnt_req #(.MAX_BYTES(MAXB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn_sys(rstn_sys),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
    .sys_req_ack(sys_req_ack), .sys_req_data(sys_req_data), .sys_req_data_valid(sys_req_data_valid),
    .sys_resp_data(sys_resp_data), .sys_resp_data_valid(sys_resp_data_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] l);
    if (l == 4'd0) return 1;
    if (int'(l) > MAXB) return MAXB;
    return int'(l);
  endfunction

  function automatic logic [7:0] src_byte(input logic [63:0] s, input int k);
    return (k < 8) ? s[8*k +: 8] : 8'hA5;
  endfunction

  function automatic logic [63:0] keep_bytes(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n && k < 8; k++) r[8*k +: 8] = v[8*k +: 8];
    return r;
  endfunction

  // Observations of one transaction
  int          o_req_cyc, o_nw, o_first_w, o_last_w, o_rsp_cnt, o_rsp_cyc;
  logic        o_fld_ok, o_wcontig, o_err, o_ready_after, o_timeout;
  logic [63:0] o_wpack, o_rdata, o_rdata_hold;

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, ".outs"}, {56'd0, rsp_valid, rsp_err, sys_req_valid, sys_req_wr,
                         sys_req_data_valid, 3'd0}, 64'd0);
    chk({tag, ".addr_data"}, {48'd0, sys_req_addr, sys_req_data}, 64'd0);
    chk({tag, ".rdata"}, rsp_rdata, 64'd0);
  endtask

  // Drives one command and plays the MAC side: ack after ack_dly REQ cycles, then
  // n_send read bytes spaced by gap idle cycles (bytes beyond len are extras).
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                         input logic [63:0] wdata, input logic [63:0] rsrc,
                         input int ack_dly, input int gap, input int n_send, input string tag);
    int ack_cyc, sent, post;
    o_req_cyc = 0; o_nw = 0; o_first_w = -1; o_last_w = -1; o_rsp_cnt = 0; o_rsp_cyc = -1;
    o_fld_ok = 1'b1; o_wcontig = 1'b1; o_err = 1'b0; o_ready_after = 1'b0;
    o_wpack = '0; o_rdata = '0;
    ack_cyc = -1; sent = 0; post = -1;
    @(negedge clk);
    chk({tag, ".ready_in"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = '0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      sys_req_ack = 1'b0; sys_resp_data_valid = 1'b0; sys_resp_data = 8'h00;
      if (sys_req_valid) begin
        if (sys_req_wr !== wr || sys_req_addr !== addr) o_fld_ok = 1'b0;
        if (o_req_cyc == ack_dly) begin sys_req_ack = 1'b1; ack_cyc = cyc; end
        o_req_cyc++;
      end
      if (sys_req_data_valid) begin
        if (o_nw == 0) o_first_w = cyc;
        else if (cyc != o_last_w + 1) o_wcontig = 1'b0;
        if (o_nw < 8) o_wpack[8*o_nw +: 8] = sys_req_data;
        o_last_w = cyc;
        o_nw++;
      end
      if (rsp_valid) begin
        o_rsp_cnt++;
        if (o_rsp_cnt == 1) begin o_rsp_cyc = cyc; o_rdata = rsp_rdata; o_err = rsp_err; post = cyc; end
      end
      if (post >= 0 && cyc == post + 1) o_ready_after = cmd_ready;
      if (!wr && ack_cyc > 0 && cyc > ack_cyc && sent < n_send &&
          ((cyc - ack_cyc - 1) % (gap + 1)) == 0) begin
        sys_resp_data_valid = 1'b1;
        sys_resp_data = src_byte(rsrc, sent);
        sent++;
      end
      if (post >= 0 && cyc == post + 4) break;
      @(negedge clk);
    end
    o_rdata_hold = rsp_rdata;
    o_timeout = (post < 0);
    sys_req_ack = 1'b0; sys_resp_data_valid = 1'b0; sys_resp_data = 8'h00;
  endtask

  task automatic check_txn(input string tag, input logic wr, input int ack_dly, input int exp_req,
                           input int exp_nw, input logic [63:0] exp_w, input logic [63:0] exp_r,
                           input logic exp_err, input int exp_rsp);
    chk({tag, ".completed"}, 64'(o_timeout), 64'd0);
    chk({tag, ".req_cycles"}, o_req_cyc, exp_req);
    chk({tag, ".req_fields"}, 64'(o_fld_ok), 64'd1);
    chk({tag, ".wbytes_n"}, o_nw, exp_nw);
    chk({tag, ".wbytes"}, o_wpack, exp_w);
    chk({tag, ".wbytes_b2b"}, 64'(o_wcontig), 64'd1);
    chk({tag, ".first_wbyte_cyc"}, o_first_w, wr ? ack_dly + 2 : -1);
    chk({tag, ".rsp_count"}, o_rsp_cnt, 1);
    chk({tag, ".rsp_cyc"}, o_rsp_cyc, exp_rsp);
    chk({tag, ".rdata"}, o_rdata, exp_r);
    chk({tag, ".err"}, 64'(o_err), 64'(exp_err));
    chk({tag, ".ready_after"}, 64'(o_ready_after), 64'd1);
    chk({tag, ".rdata_hold"}, o_rdata_hold, exp_r);
  endtask

  // Higher-level model: byte lists truncated to the effective length; timing from
  // the handshake schedule (REQ from cycle 1, one byte per cycle or per gap).
  task automatic model_check(input string tag, input logic wr, input logic [3:0] len,
                             input logic [63:0] wdata, input logic [63:0] rsrc,
                             input int ack_dly, input int gap);
    int l, rsp;
    l = eff_len(len);
    rsp = wr ? (ack_dly + 2 + l) : (ack_dly + 2 + (l - 1) * (gap + 1) + 1);
    check_txn(tag, wr, ack_dly, ack_dly + 1, wr ? l : 0, wr ? keep_bytes(wdata, l) : 64'd0,
              wr ? 64'd0 : keep_bytes(rsrc, l), 1'b0, rsp);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [63:0] wdata;
    logic [63:0] rsrc;
    int          ack_dly;
    int          gap;
    int          n_send;
    int          exp_n;
    logic [63:0] exp_w;
    logic [63:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  logic        r_wr;
  logic [7:0]  r_addr;
  logic [3:0]  r_len;
  logic [63:0] r_wdata, r_rsrc;
  int          r_ack, r_gap, r_n;
  logic [9:0]  hold_rdy;
  int          hold_rsp_n, hold_rsp1, hold_rsp2, rst_rsp_n;
  logic [7:0]  hold_addr;
  logic [63:0] hold_rd;
  logic        prev_rd_ack;

  initial begin
    vecs[0] = '{1'b1, 8'h10, 4'd2,  64'hBEEF,                64'h0,                   3, 0, 0, 2, 64'hBEEF,                64'h0};
    vecs[1] = '{1'b0, 8'h22, 4'd4,  64'h0,                   64'h0000_00EE_4433_2211, 1, 1, 5, 0, 64'h0,                   64'h4433_2211};
    vecs[2] = '{1'b1, 8'h05, 4'd0,  64'hDEAD_BEEF_CAFE_1177, 64'h0,                   0, 0, 0, 1, 64'h77,                  64'h0};
    vecs[3] = '{1'b1, 8'h7F, 4'd15, 64'h0123_4567_89AB_CDEF, 64'h0,                   1, 0, 0, 8, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[4] = '{1'b0, 8'h30, 4'd0,  64'h0,                   64'h0000_0000_0000_CDAB, 0, 0, 2, 0, 64'h0,                   64'hAB};
    vecs[5] = '{1'b0, 8'h31, 4'd15, 64'h0,                   64'h8877_6655_4433_2211, 2, 0, 9, 0, 64'h0,                   64'h8877_6655_4433_2211};
    vecs[6] = '{1'b0, 8'h32, 4'd8,  64'h0,                   64'hF0E0_D0C0_B0A0_9080, 4, 2, 8, 0, 64'h0,                   64'hF0E0_D0C0_B0A0_9080};
    vecs[7] = '{1'b1, 8'h33, 4'd3,  64'h1122_3344_5566,      64'h0,                   0, 0, 0, 3, 64'h44_5566,             64'h0};

    rstn_sys = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_len = 4'd0;
    cmd_wdata = '0; sys_req_ack = 1'b0; sys_resp_data = 8'h00; sys_resp_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn_sys = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, vecs[i].rsrc,
              vecs[i].ack_dly, vecs[i].gap, vecs[i].n_send, $sformatf("vec%0d", i));
      check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].ack_dly, vecs[i].ack_dly + 1,
                vecs[i].exp_n, vecs[i].exp_w, vecs[i].exp_r, 1'b0,
                vecs[i].wr ? vecs[i].ack_dly + 2 + eff_len(vecs[i].len)
                           : vecs[i].ack_dly + 2 + (eff_len(vecs[i].len) - 1) * (vecs[i].gap + 1) + 1);
    end

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_addr = 8'($urandom);
      r_len = 4'($urandom_range(0, 15));
      r_wdata = {$urandom, $urandom};
      r_rsrc = {$urandom, $urandom};
      r_ack = $urandom_range(0, 4);
      r_gap = $urandom_range(0, 3);
      r_n = eff_len(r_len) + $urandom_range(0, 2);
      run_txn(r_wr, r_addr, r_len, r_wdata, r_rsrc, r_ack, r_gap, r_n, $sformatf("rnd%0d", i));
      model_check($sformatf("rnd%0d", i), r_wr, r_len, r_wdata, r_rsrc, r_ack, r_gap);
    end

    // Reset in the middle of a read, after 2 of 4 bytes.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h66; cmd_len = 4'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    sys_req_ack = sys_req_valid;
    @(negedge clk);
    sys_req_ack = 1'b0; sys_resp_data_valid = 1'b1; sys_resp_data = 8'h01;
    @(negedge clk);
    sys_resp_data = 8'h02;
    @(negedge clk);
    sys_resp_data_valid = 1'b0; sys_resp_data = 8'h00;
    chk("rst_mid.partial", rsp_rdata, 64'h0201);
    rstn_sys = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rstn_sys = 1'b1;
    rst_rsp_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) rst_rsp_n++;
      @(negedge clk);
    end
    chk("rst_mid.no_rsp", rst_rsp_n, 0);
    run_txn(1'b0, 8'h67, 4'd4, 64'h0, 64'hD4C3_B2A1, 1, 0, 4, "rst_after");
    model_check("rst_after", 1'b0, 4'd4, 64'h0, 64'hD4C3_B2A1, 1, 0);

    // cmd_valid held while busy: second command waits for the first response.
    hold_rdy = '0; hold_rsp_n = 0; hold_rsp1 = -1; hold_rsp2 = -1; hold_addr = 8'h00;
    hold_rd = '0; prev_rd_ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h31; cmd_len = 4'd1; cmd_wdata = 64'h5E;
    for (int c = 0; c < 10; c++) begin
      sys_req_ack = 1'b0; sys_resp_data_valid = 1'b0; sys_resp_data = 8'h00;
      hold_rdy[c] = cmd_ready;
      if (rsp_valid) begin
        hold_rsp_n++;
        if (hold_rsp_n == 1) hold_rsp1 = c;
        else begin hold_rsp2 = c; hold_rd = rsp_rdata; end
      end
      if (prev_rd_ack) begin sys_resp_data_valid = 1'b1; sys_resp_data = 8'h9C; end
      prev_rd_ack = 1'b0;
      if (sys_req_valid) begin
        sys_req_ack = 1'b1;
        if (!sys_req_wr) begin prev_rd_ack = 1'b1; hold_addr = sys_req_addr; cmd_valid = 1'b0; end
      end
      if (c == 1) begin cmd_wr = 1'b0; cmd_addr = 8'h42; cmd_wdata = '0; end
      @(negedge clk);
    end
    sys_req_ack = 1'b0; sys_resp_data_valid = 1'b0; cmd_valid = 1'b0;
    chk("hold.ready_pattern", 64'(hold_rdy), 64'h311);
    chk("hold.rsp_count", hold_rsp_n, 2);
    chk("hold.rsp1_cyc", hold_rsp1, 3);
    chk("hold.rsp2_cyc", hold_rsp2, 7);
    chk("hold.addr2", 64'(hold_addr), 64'h42);
    chk("hold.rdata2", hold_rd, 64'h9C);

`ifdef MGNT_REQ_TIMEOUT_EN
    run_txn(1'b0, 8'h70, 4'd2, 64'h0, 64'h0, 1000, 0, 0, "tmo_ack");
    check_txn("tmo_ack", 1'b0, 1000, TMO, 0, 64'h0, 64'h0, 1'b1, TMO + 1);
    run_txn(1'b0, 8'h71, 4'd3, 64'h0, 64'h5A, 0, 0, 1, "tmo_rd");
    check_txn("tmo_rd", 1'b0, 0, 1, 0, 64'h0, 64'h5A, 1'b1, TMO + 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
